// File: rtl/mp_add_seq.sv
// Multi-word add/subtract that reuses one 64-bit carry-select adder,
// walking the operands LSW first, one word per clock.
module csa64 (
  input  logic [63:0] x,
  input  logic [63:0] y,
  input  logic        ci,
  output logic [63:0] s,
  output logic        co
);

  logic [32:0] lo;
  logic [32:0] hi0;
  logic [32:0] hi1;

  // Upper half is precomputed for both incoming carries.
  always_comb begin
    lo  = {1'b0, x[31:0]} + {1'b0, y[31:0]} + {32'd0, ci};
    hi0 = {1'b0, x[63:32]} + {1'b0, y[63:32]};
    hi1 = {1'b0, x[63:32]} + {1'b0, y[63:32]} + 33'd1;
    s   = {(lo[32] ? hi1[31:0] : hi0[31:0]), lo[31:0]};
    co  = lo[32] ? hi1[32] : hi0[32];
  end

endmodule

module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_sub,
  input  logic [64*WORDS-1:0] a,
  input  logic [64*WORDS-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [64*WORDS-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  localparam int N  = 64 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  work_q;
  logic [N-1:0]  work_d;
  logic          op_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic [IW+5:0] off;

  logic [63:0] x;
  logic [63:0] bw;
  logic [63:0] y;
  logic [63:0] s;
  logic        co;
  logic        last;
  logic        load;
  logic        step;

  csa64 u_add (
    .x  (x),
    .y  (y),
    .ci (carry_q),
    .s  (s),
    .co (co)
  );

  always_comb begin
    off    = {idx_q, 6'd0};
    x      = a_q[off +: 64];
    bw     = b_q[off +: 64];
    y      = op_q ? ~bw : bw;
    last   = (idx_q == IW'(WORDS - 1));
    work_d = work_q;
    work_d[off +: 64] = s;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_q     <= a;
        b_q     <= b;
        op_q    <= op_sub;
        carry_q <= op_sub;
        idx_q   <= '0;
      end else if (step) begin
        work_q  <= work_d;
        carry_q <= co;
        idx_q   <= last ? '0 : idx_q + IW'(1);
        // Last word: the MSW operands and sum give the signed overflow.
        if (last) begin
          sum  <= work_d;
          cout <= co;
          ovf  <= (x[63] == y[63]) && (s[63] != x[63]);
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: fixed vectors, random ops against an
// arithmetic model, and start/reset corner sequences.
module tb_mp_add_seq;

  localparam int W = 4;
  localparam int N = 64 * W;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks;
  int errors;

  mp_add_seq #(.WORDS(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic         vsub;
    logic [N-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) begin
      r[i*32 +: 32] = $urandom;
    end
    if ($urandom_range(0, 3) == 0) begin
      r[($urandom_range(0, W - 1))*64 +: 64] = '1;
    end
    return r;
  endfunction

  // Whole-width arithmetic, no word slicing.
  task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                       input logic msub, output logic [N-1:0] ms,
                       output logic mc, output logic mo);
    logic [N-1:0] bp;
    logic [N:0]   full;
    bp   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bp} + {{N{1'b0}}, msub};
    ms   = full[N-1:0];
    mc   = full[N];
    mo   = (ma[N-1] == bp[N-1]) && (ms[N-1] != ma[N-1]);
  endtask

  task automatic run_op(input string nm, input logic [N-1:0] ia,
                        input logic [N-1:0] ib, input logic isub,
                        input logic [N-1:0] es, input logic ec,
                        input logic eo);
    int n;
    int bcnt;
    int chg;
    logic got;
    logic [N-1:0] prev;
    a      = ia;
    b      = ib;
    op_sub = isub;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    a      = rnd();
    b      = rnd();
    op_sub = ~isub;
    prev   = sum;
    n = 0;
    bcnt = 0;
    chg = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      if (busy) bcnt++;
      if (sum !== prev) chg++;
      tick();
      n++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end
    chk({nm, "_lat"}, N'(n), N'(W));
    chk({nm, "_busy"}, N'(bcnt), N'(W));
    chk({nm, "_hold"}, N'(chg), N'(0));
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, N'(cout), N'(ec));
    chk({nm, "_ovf"}, N'(ovf), N'(eo));
    tick();
    chk({nm, "_pulse"}, N'(done), N'(0));
  endtask

  initial begin
    logic [N-1:0] ones;
    logic [N-1:0] a1, b1, a2, b2, a3, b3, ms;
    logic         s1, s3, mc, mo;
    logic [N-1:0] r1;
    logic         c1, o1;
    int           dn;

    checks = 0;
    errors = 0;
    ones   = '1;

    vecs[0] = '{ones, N'(1), 1'b0, N'(0), 1'b1, 1'b0};
    vecs[1] = '{N'(5), N'(7), 1'b1, ~N'(1), 1'b0, 1'b0};
    vecs[2] = '{ones >> 1, N'(1), 1'b0, ~(ones >> 1), 1'b0, 1'b1};
    vecs[3] = '{N'(0), N'(0), 1'b0, N'(0), 1'b0, 1'b0};
    vecs[4] = '{N'(0), N'(1), 1'b1, ones, 1'b0, 1'b0};
    vecs[5] = '{~(ones >> 1), N'(1), 1'b1, ones >> 1, 1'b1, 1'b1};
    vecs[6] = '{ones >> (N - 64), N'(1), 1'b0, N'(1) << 64, 1'b0, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    #23;
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_done", N'(done), N'(0));
    chk("rst_sum", sum, N'(0));
    chk("rst_cout", N'(cout), N'(0));
    chk("rst_ovf", N'(ovf), N'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
             vecs[i].vsub, vecs[i].es, vecs[i].ec, vecs[i].eo);
    end

    for (int i = 0; i < 30; i++) begin
      a1 = rnd();
      b1 = rnd();
      s1 = 1'($urandom_range(0, 1));
      model(a1, b1, s1, ms, mc, mo);
      run_op($sformatf("rnd%0d", i), a1, b1, s1, ms, mc, mo);
    end

    // Start during RUN is ignored; start alongside done is taken.
    a1 = rnd();
    b1 = rnd();
    s1 = 1'b1;
    a2 = rnd();
    b2 = rnd();
    a3 = rnd();
    b3 = rnd();
    s3 = 1'b0;
    a = a1;
    b = b1;
    op_sub = s1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = a2;
    b = b2;
    op_sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("b2b_busy_k3", N'(busy), N'(1));
    tick();
    model(a1, b1, s1, r1, c1, o1);
    chk("b2b_done1", N'(done), N'(1));
    chk("b2b_sum1", sum, r1);
    chk("b2b_cout1", N'(cout), N'(c1));
    a = a3;
    b = b3;
    op_sub = s3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy_k5", N'(busy), N'(1));
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dn++;
    end
    chk("b2b_early_done", N'(dn), N'(0));
    tick();
    model(a3, b3, s3, r1, c1, o1);
    chk("b2b_done2", N'(done), N'(1));
    chk("b2b_sum2", sum, r1);
    chk("b2b_ovf2", N'(ovf), N'(o1));
    tick();

    // Reset pulse mid-operation.
    a = ones;
    b = ones;
    op_sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", N'(busy), N'(0));
    chk("rst_mid_done", N'(done), N'(0));
    chk("rst_mid_sum", sum, N'(0));
    chk("rst_mid_cout", N'(cout), N'(0));
    chk("rst_mid_ovf", N'(ovf), N'(0));
    #1;
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy || sum !== '0) dn++;
    end
    chk("rst_abort", N'(dn), N'(0));
    run_op("post_rst", N'(5), N'(7), 1'b1, ~N'(1), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
